radio_dummy: RTL and testbench

- Synthetic single-antenna radio front-end model for correlator benches.
- Emits 1-bit I/Q sign samples at the signal clock.
- All instances share one deterministic "sky source" sequence, delayed by ANT_NUM samples per antenna, so the correlator sees known, nonzero cross-correlations at known lags.
- A per-antenna pseudo-random noise term partially decorrelates the antennas.

---
 rtl/radio_dummy.sv | 61 ++++++
 tb/tb_radio_dummy.sv | 84 ++++++++
 2 files changed

// File: rtl/radio_dummy.sv
// radio_dummy: synthetic 1-bit I/Q front end; shared LFSR sky source delayed by ANT_NUM samples.
// Define RADIO_DUMMY_NOISE_EN to add a per-antenna noise LFSR that flips output bits.
module radio_dummy #(
  parameter int          ANT_NUM   = 0,
  parameter int          MAX_DELAY = 24,
  parameter logic [15:0] SRC_SEED  = 16'hACE1
) (
  input  logic clk16,
  input  logic rst_n,
  input  logic i1,
  input  logic q1,
  output logic data_i,
  output logic data_q
);
  localparam int STAGES = (ANT_NUM < MAX_DELAY) ? ANT_NUM : MAX_DELAY - 1;
  logic [15:0] src;
  logic [1:0]  cur, del;
  logic        fi, fq, i1_unused, q1_unused;
  assign cur = {src[0], src[8]};
  generate
    if (STAGES == 0) begin : g_bypass
      assign del = cur;
    end else begin : g_line
      logic [1:0] line [STAGES];
      always_ff @(posedge clk16 or negedge rst_n)
        if (!rst_n) begin
          for (int j = 0; j < STAGES; j++) line[j] <= '0;
        end else begin
          line[0] <= cur;
          for (int j = 1; j < STAGES; j++) line[j] <= line[j-1];
        end
      assign del = line[STAGES-1];
    end
  endgenerate
`ifdef RADIO_DUMMY_NOISE_EN
  localparam logic [7:0] ANT8 = 8'(ANT_NUM);
  logic [15:0] noise;
  always_ff @(posedge clk16 or negedge rst_n)
    if (!rst_n) noise <= {8'h5A, ANT8 ^ 8'hC3};
    else        noise <= {noise[0] ^ noise[1] ^ noise[3] ^ noise[12], noise[15:1]};
  assign fi = noise[0] & noise[1];
  assign fq = noise[2] & noise[3];
`else
  assign fi = 1'b0;
  assign fq = 1'b0;
`endif
  always_ff @(posedge clk16 or negedge rst_n)
    if (!rst_n) begin
      src       <= SRC_SEED;
      data_i    <= 1'b0;
      data_q    <= 1'b0;
      i1_unused <= 1'b0;
      q1_unused <= 1'b0;
    end else begin
      src       <= {src[0] ^ src[2] ^ src[3] ^ src[5], src[15:1]};
      data_i    <= del[1] ^ fi;
      data_q    <= del[0] ^ fq;
      i1_unused <= i1;
      q1_unused <= q1;
    end
endmodule

// File: tb/tb_radio_dummy.sv
// tb_radio_dummy: directed checks of radio_dummy (noise disabled) against a bench-side source LFSR model.
module tb_radio_dummy;
  logic clk16 = 1'b0;
  logic rst_n, i1r, q1r;
  logic d0i, d0q, d3i, d3q, dri, drq;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] m;
  logic [1:0]  exp0, exp3;
  logic [1:0]  hist [1:50];
  logic [1:0]  ring [4];

  always #5 clk16 = ~clk16;

  radio_dummy #(.ANT_NUM(0)) u0 (.clk16(clk16), .rst_n(rst_n), .i1(1'b0), .q1(1'b0), .data_i(d0i), .data_q(d0q));
  radio_dummy #(.ANT_NUM(3)) u3 (.clk16(clk16), .rst_n(rst_n), .i1(1'b0), .q1(1'b0), .data_i(d3i), .data_q(d3q));
  radio_dummy #(.ANT_NUM(0)) ur (.clk16(clk16), .rst_n(rst_n), .i1(i1r), .q1(q1r), .data_i(dri), .data_q(drq));

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i1r   = 1'b0;
    q1r   = 1'b0;
    repeat (5) begin
      @(negedge clk16);
      check("rst_hold_a0", {d0i, d0q}, 2'b00);
      check("rst_hold_a3", {d3i, d3q}, 2'b00);
    end
    @(negedge clk16) rst_n = 1'b1;
    m = 16'hACE1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk16);
      i1r = 1'($urandom);
      q1r = 1'($urandom);
      #1;
      exp0 = {m[0], m[8]};
      m = step(m);
      exp3 = (k <= 3) ? 2'b00 : ring[(k - 3) % 4];
      ring[k % 4] = exp0;
      hist[k] = exp0;
      if (k == 1) check("first_edge", {d0i, d0q}, 2'b10);
      check("ph1_a0", {d0i, d0q}, exp0);
      check("ph1_a3", {d3i, d3q}, exp3);
      check("ph1_iq_fb", {dri, drq}, exp0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a0", {d0i, d0q}, 2'b00);
    check("async_rst_a3", {d3i, d3q}, 2'b00);
    check("async_rst_fb", {dri, drq}, 2'b00);
    @(posedge clk16);
    #1 check("rst_edge_a0", {d0i, d0q}, 2'b00);
    @(negedge clk16) rst_n = 1'b1;
    m = 16'hACE1;
    for (int k = 1; k <= 65535 + 40; k++) begin
      @(posedge clk16);
      i1r = 1'($urandom);
      q1r = 1'($urandom);
      #1;
      exp0 = {m[0], m[8]};
      m = step(m);
      exp3 = (k <= 3) ? 2'b00 : ring[(k - 3) % 4];
      ring[k % 4] = exp0;
      check("ph2_a0", {d0i, d0q}, exp0);
      check("ph2_a3", {d3i, d3q}, exp3);
      check("ph2_iq_fb", {dri, drq}, exp0);
      if (k <= 50) check("restart_identical", {d0i, d0q}, hist[k]);
      if (k > 65535) check("period_wrap", {d0i, d0q}, hist[k - 65535]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
